alu_sequencer: RTL and testbench

The ALU sequencer shares the 16-bit ALU between two requesters: port 0, the instruction-execute stage, and port 1, the address/DMA unit. It arbitrates round-robin, latches operands, and drives the ALU `execute`, `op`, `shift` and source inputs for a fixed number of settle cycles. It then captures `ALU_result` and `flags` and returns them on a single response channel with valid/ready backpressure. It is the only block that drives the ALU.

---
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one ALU between the instruction-execute stage (port 0)
// and the address/DMA unit (port 1). Round-robin arbitration, operand latch,
// ALU_LAT cycles of execute, then one response on a valid/ready channel.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Requesters hold valid and payload stable until ready; dropping valid early
// withdraws the request. reqN_ready is combinational from the valids and only
// high in IDLE. rsp_* is held stable while rsp_valid && !rsp_ready.
module alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_shift,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_shift,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic             alu_execute,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_shift,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flags,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // Counter reload: execute is held for ALU_LAT cycles (legal range 1..4).
  localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic [1:0]       lat_cnt;
  logic             id_q;

  logic             any_valid;
  logic             grant1;
  logic             accept;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_shift;
  logic             sel_illegal;

  // Arbitration and payload select: a tie goes to the port that did not win last.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    grant1      = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant;
    end else begin
      grant1 = req1_valid;
    end
    accept      = reset_n && (state == S_IDLE) && any_valid;
    req0_ready  = accept && !grant1;
    req1_ready  = accept && grant1;
    sel_op      = grant1 ? req1_op    : req0_op;
    sel_a       = grant1 ? req1_a     : req0_a;
    sel_b       = grant1 ? req1_b     : req0_b;
    sel_shift   = grant1 ? req1_shift : req0_shift;
    sel_illegal = (sel_op > 4'd9);
  end

  // Status outputs decoded from the FSM state; dbg_state exposes the raw state.
  always_comb begin
    alu_execute = (state == S_ISSUE);
    rsp_valid   = (state == S_RESP);
    dbg_state   = state;
  end

  // FSM, operand latch and response capture. The alu_* operand registers keep
  // their last value outside ISSUE so the ALU's held output does not glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lat_cnt    <= 2'd0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      rsp_err    <= 1'b0;
      alu_op     <= 4'd0;
      alu_shift  <= 4'd0;
      alu_src1   <= '0;
      alu_src2   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_op     <= sel_op;
            alu_shift  <= sel_shift;
            alu_src1   <= sel_a;
            alu_src2   <= sel_b;
            id_q       <= grant1;
            last_grant <= grant1;
            if (sel_illegal) begin
              // Illegal opcode: never touch the ALU, answer with an error.
              rsp_id     <= grant1;
              rsp_result <= '0;
              rsp_flags  <= 3'b000;
              rsp_err    <= 1'b1;
              state      <= S_RESP;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (lat_cnt == 2'd0) begin
            rsp_id     <= id_q;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
            state      <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU, a table of vectors applied in a
// loop, hand-written sequences for backpressure, reset and round-robin, and a
// response scoreboard fed at acceptance time.
module tb_alu_sequencer;
  localparam int W   = 16;
  localparam int LAT = 3;

  typedef struct {
    logic         id;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sh;
    logic [W-1:0] res;
    logic [2:0]   fl;
    logic         err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (ALU_LAT = LAT) ----------------
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req0_shift, req1_op, req1_shift;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, alu_execute;
  logic [W-1:0] rsp_result, alu_src1, alu_src2, alu_result;
  logic [2:0]   rsp_flags, alu_flags;
  logic [3:0]   alu_op, alu_shift;
  logic [1:0]   dbg_state;

  alu_sequencer #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_execute(alu_execute), .alu_op(alu_op), .alu_shift(alu_shift),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_flags(alu_flags), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (ALU_LAT = 1) ----------------
  logic         s_req0_valid, s_req0_ready, s_req1_ready;
  logic [3:0]   s_req0_op;
  logic [W-1:0] s_req0_a, s_req0_b;
  logic         s_rsp_valid, s_rsp_id, s_rsp_err, s_alu_execute;
  logic [W-1:0] s_rsp_result, s_alu_src1, s_alu_src2, s_alu_result;
  logic [2:0]   s_rsp_flags, s_alu_flags;
  logic [3:0]   s_alu_op, s_alu_shift;
  logic [1:0]   s_dbg_state;

  alu_sequencer #(.WIDTH(W), .ALU_LAT(1)) dut_lat1 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(s_req0_op),
    .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_shift(4'd0),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_op(4'd0),
    .req1_a(16'h0000), .req1_b(16'h0000), .req1_shift(4'd0),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags), .rsp_err(s_rsp_err),
    .alu_execute(s_alu_execute), .alu_op(s_alu_op), .alu_shift(s_alu_shift),
    .alu_src1(s_alu_src1), .alu_src2(s_alu_src2),
    .alu_result(s_alu_result), .alu_flags(s_alu_flags), .dbg_state(s_dbg_state)
  );

  // Behavioural ALU: returns {n,c,z, result}.
  function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [3:0] sh);
    logic [W:0]   w;
    logic [W-1:0] r;
    logic         c;
    w = '0; r = '0; c = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[W-1:0]; c = w[W]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: r = (a << sh) | (a >> (5'd16 - {1'b0, sh}));
      4'd9: r = a * b;
      default: r = '0;
    endcase
    return {r[W-1], c, (r == '0), r};
  endfunction

  always_comb {alu_flags, alu_result}     = alu_model(alu_op, alu_src1, alu_src2, alu_shift);
  always_comb {s_alu_flags, s_alu_result} = alu_model(s_alu_op, s_alu_src1, s_alu_src2, s_alu_shift);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [20:0]  exp_q[$];
  logic [20:0]  mon_e;
  logic [3:0]   cur_op, cur_sh;
  logic [W-1:0] cur_a, cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no event within bound, expected one", name);
  endtask

  // Monitor: ALU drive during execute, and response pop/compare on handshake.
  always @(negedge clk) begin
    if (reset_n && alu_execute) begin
      chk("alu_op", alu_op, cur_op);
      chk("alu_src1", alu_src1, cur_a);
      chk("alu_src2", alu_src2, cur_b);
      chk("alu_shift", alu_shift, cur_sh);
    end
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp_absent");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", {11'b0, rsp_id, rsp_err, rsp_flags, rsp_result}, {11'b0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input bit port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  // One full transaction with rsp_ready high; reports execute cycles and the
  // cycle (after the accept edge) in which rsp_valid first appears.
  task automatic send(input vec_t v, output int n_exec, output int rsp_k);
    bit ok;
    n_exec = 0; rsp_k = 0;
    cur_op = v.op; cur_a = v.a; cur_b = v.b; cur_sh = v.sh;
    if (v.id) begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_shift = v.sh;
    end else begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_shift = v.sh;
    end
    wait_ready(v.id, ok);
    if (!ok) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    exp_q.push_back({v.id, v.err, v.fl, v.res});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (alu_execute) n_exec++;
      if (rsp_valid && rsp_k == 0) rsp_k = k;
      if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("rsp_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[11];
  int   ne, rk, last, seen;
  bit   ok;

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  16'h0003, 16'h0004, 4'd0,  16'h0007, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 4'd0,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b011, 1'b0};
    vecs[2]  = '{1'b1, 4'd1,  16'h0003, 16'h0005, 4'd0,  16'hFFFE, 3'b110, 1'b0};
    vecs[3]  = '{1'b0, 4'd2,  16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 3'b000, 1'b0};
    vecs[4]  = '{1'b1, 4'd4,  16'hAAAA, 16'hAAAA, 4'd0,  16'h0000, 3'b001, 1'b0};
    vecs[5]  = '{1'b0, 4'd6,  16'h0001, 16'h0000, 4'd15, 16'h8000, 3'b100, 1'b0};
    vecs[6]  = '{1'b1, 4'd9,  16'h0010, 16'h0020, 4'd0,  16'h0200, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 4'd8,  16'h8001, 16'h0000, 4'd4,  16'h0018, 3'b000, 1'b0};
    vecs[8]  = '{1'b0, 4'd12, 16'h1234, 16'h5678, 4'd0,  16'h0000, 3'b000, 1'b1};
    vecs[9]  = '{1'b1, 4'd15, 16'h0001, 16'h0001, 4'd0,  16'h0000, 3'b000, 1'b1};
    vecs[10] = '{1'b0, 4'd1,  16'h0005, 16'h0005, 4'd0,  16'h0000, 3'b001, 1'b0};

    reset_n = 1'b0; rsp_ready = 1'b1;
    req0_op = 4'd0; req0_a = '0; req0_b = '0; req0_shift = 4'd0;
    req1_op = 4'd0; req1_a = '0; req1_b = '0; req1_shift = 4'd0;
    s_req0_valid = 1'b0; s_req0_op = 4'd0; s_req0_a = '0; s_req0_b = '0;
    cur_op = 4'd0; cur_a = '0; cur_b = '0; cur_sh = 4'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    // Reset state: outputs zero even with both valids high.
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_bus", {rsp_id, rsp_err, rsp_flags, rsp_result}, 0);
    chk("rst_alu_execute", alu_execute, 0);
    chk("rst_alu_bus", {alu_op, alu_shift, alu_src1}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single add on the ALU_LAT=1 instance.
    s_req0_valid = 1'b1; s_req0_op = 4'd0; s_req0_a = 16'h0003; s_req0_b = 16'h0004;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_req0_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("lat1_accept_timeout");
    @(posedge clk); #1;
    s_req0_valid = 1'b0;
    ne = 0; rk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (s_alu_execute) ne++;
      if (s_rsp_valid) begin
        rk = k;
        chk("lat1_rsp", {s_rsp_id, s_rsp_err, s_rsp_flags, s_rsp_result}, {1'b0, 1'b0, 3'b000, 16'h0007});
        break;
      end
    end
    chk("lat1_exec_cycles", ne, 1);
    chk("lat1_rsp_latency", rk, 2);
    @(posedge clk); #1;

    // Table-driven vectors on the main instance.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i], ne, rk);
      chk("exec_cycles", ne, vecs[i].err ? 0 : LAT);
      chk("rsp_latency", rk, vecs[i].err ? 1 : LAT + 1);
    end

    // Backpressure: multiply held in RESP for 5 cycles with req0 waiting.
    rsp_ready = 1'b0;
    cur_op = 4'd9; cur_a = 16'h0010; cur_b = 16'h0020; cur_sh = 4'd0;
    req1_valid = 1'b1; req1_op = 4'd9; req1_a = 16'h0010; req1_b = 16'h0020; req1_shift = 4'd0;
    wait_ready(1'b1, ok);
    exp_q.push_back({1'b1, 1'b0, 3'b000, 16'h0200});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 16'h00FF; req0_b = 16'hFF00; req0_shift = 4'd0;
    ne = 0; ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (alu_execute) ne++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("bp_rsp_timeout");
    chk("bp_exec_cycles", ne, 3);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_held", {rsp_id, rsp_err, rsp_flags, rsp_result}, {1'b1, 1'b0, 3'b000, 16'h0200});
      chk("bp_req0_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", req0_ready, 0);
    cur_op = 4'd3; cur_a = 16'h00FF; cur_b = 16'hFF00; cur_sh = 4'd0;
    @(negedge clk);
    chk("bp_next_ready", req0_ready, 1);
    exp_q.push_back({1'b0, 1'b0, 3'b100, 16'hFFFF});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Reset in the middle of ISSUE.
    cur_op = 4'd2; cur_a = 16'h1234; cur_b = 16'h00FF; cur_sh = 4'd5;
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h1234; req0_b = 16'h00FF; req0_shift = 4'd5;
    wait_ready(1'b0, ok);
    @(posedge clk); #1;
    chk("mid_rst_pre_exec", alu_execute, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_alu_execute", alu_execute, 0);
    chk("mid_rst_alu_bus", {alu_op, alu_shift, alu_src1, alu_src2}, 0);
    chk("mid_rst_rsp_bus", {rsp_valid, rsp_err, rsp_flags, rsp_result}, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    @(posedge clk); #1;

    // Round-robin with both valids held: expect 0,1,0,1 spaced LAT+2 apart.
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0001; req0_shift = 4'd0;
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'h00F0; req1_b = 16'h0F00; req1_shift = 4'd0;
    last = 0;
    for (int t = 0; t < 4; t++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin fail_now("rr_timeout"); break; end
      chk("rr_double_grant", {req0_ready, req1_ready} == 2'b11, 0);
      chk("rr_order", req1_ready, t % 2);
      if (t > 0) chk("rr_spacing", cyc - last, LAT + 2);
      last = cyc;
      if (req1_ready) begin
        exp_q.push_back({1'b1, 1'b0, 3'b000, 16'h0FF0});
        cur_op = 4'd4; cur_a = 16'h00F0; cur_b = 16'h0F00; cur_sh = 4'd0;
      end else begin
        exp_q.push_back({1'b0, 1'b0, 3'b000, 16'h0002});
        cur_op = 4'd0; cur_a = 16'h0001; cur_b = 16'h0001; cur_sh = 4'd0;
      end
      @(posedge clk); #1;
      if (t == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
